caesar_clk_gate_ctrl: RTL and testbench

- Controller that drives the enable input of the Caesar clock-gating cell wrapper.
- Gates the Caesar clock after a programmable number of consecutive idle cycles.
- Wakes the clock on a bus request, Caesar busy, or a software override, and holds the requester's grant until the clock has settled for WAKE_CYCLES cycles.
- Sits in the always-on clock domain between the bus/SW config registers and the clock gate; also provides gating statistics.

---
 rtl/caesar_clk_gate_ctrl.sv | 142 ++++++++++++++
 tb/tb_caesar_clk_gate_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/caesar_clk_gate_ctrl.sv
// caesar_clk_gate_ctrl
//
// Drives the enable of the Caesar clock-gating cell from the always-on
// domain. The Caesar clock is gated after IDLE_CYCLES consecutive idle
// cycles. It is woken by a bus request, by Caesar busy, or by a software
// override. A bus request is granted only once the clock has run for
// WAKE_CYCLES cycles. The block also counts gated cycles and wake events.
//
// Ports:
//   clk_i           free-running (ungated) clock
//   rst_i           asynchronous, active-high reset
//   sw_gate_en_i    1 = automatic gating allowed, 0 = clock kept on
//   sw_force_en_i   1 = force clock on
//   req_i           bus request targeting Caesar, held until gnt_o
//   busy_i          Caesar internal activity
//   gnt_o           grant, combinational, only in ACTIVE
//   clk_en_o        registered enable to the clock-gate cell
//   state_o         0=GATED, 1=WAKE, 2=ACTIVE
//   clr_stats_i     synchronous clear of the statistics counters
//   gated_cycles_o  saturating count of cycles spent in GATED
//   wake_events_o   saturating count of exits from GATED
module caesar_clk_gate_ctrl #(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W = $clog2(((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        sw_gate_en_i,
   input  logic        sw_force_en_i,
   input  logic        req_i,
   input  logic        busy_i,
   output logic        gnt_o,
   output logic        clk_en_o,
   output logic [1:0]  state_o,
   input  logic        clr_stats_i,
   output logic [31:0] gated_cycles_o,
   output logic [15:0] wake_events_o
);

   localparam logic [1:0] ST_GATED  = 2'd0;
   localparam logic [1:0] ST_WAKE   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LOAD = (WAKE_CYCLES > 0) ? CNT_W'(WAKE_CYCLES - 1) : '0;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             clk_en_q, clk_en_d;
   logic [31:0]      gated_cycles_q, gated_cycles_d;
   logic [15:0]      wake_events_q, wake_events_d;
   logic             wake;

   assign wake = req_i | busy_i | sw_force_en_i | ~sw_gate_en_i;

   // The single counter counts down the settle time in WAKE and counts
   // up the consecutive idle cycles in ACTIVE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_GATED: begin
            if (wake) begin
               if (WAKE_CYCLES > 0) begin
                  state_d = ST_WAKE;
                  cnt_d   = WAKE_LOAD;
               end else begin
                  state_d = ST_ACTIVE;
                  cnt_d   = '0;
               end
            end
         end
         ST_WAKE: begin
            // A wake cause that goes away here does not abort the wake.
            if (cnt_q == '0) begin
               state_d = ST_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (wake) begin
               cnt_d = '0;
            end else if (cnt_q == IDLE_LAST) begin
               state_d = ST_GATED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_GATED;
            cnt_d   = '0;
         end
      endcase
   end

   // Registering the enable from the next state keeps it glitch-free and
   // aligned with the state register.
   assign clk_en_d = (state_d != ST_GATED);

   always_comb begin
      gated_cycles_d = gated_cycles_q;
      wake_events_d  = wake_events_q;
      if (clr_stats_i) begin
         gated_cycles_d = '0;
         wake_events_d  = '0;
      end else begin
         if ((state_q == ST_GATED) && (gated_cycles_q != 32'hFFFF_FFFF)) begin
            gated_cycles_d = gated_cycles_q + 32'd1;
         end
         if ((state_q == ST_GATED) && (state_d != ST_GATED) && (wake_events_q != 16'hFFFF)) begin
            wake_events_d = wake_events_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q        <= ST_GATED;
         cnt_q          <= '0;
         clk_en_q       <= 1'b0;
         gated_cycles_q <= '0;
         wake_events_q  <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         clk_en_q       <= clk_en_d;
         gated_cycles_q <= gated_cycles_d;
         wake_events_q  <= wake_events_d;
      end
   end

   assign gnt_o          = (state_q == ST_ACTIVE) & req_i;
   assign clk_en_o       = clk_en_q;
   assign state_o        = state_q;
   assign gated_cycles_o = gated_cycles_q;
   assign wake_events_o  = wake_events_q;

endmodule

// File: tb/tb_caesar_clk_gate_ctrl.sv
module tb_caesar_clk_gate_ctrl;

   localparam int IDLE   = 16;
   localparam int WAKE_A = 2;
   localparam int WAKE_B = 0;

   logic        clk = 1'b0;
   logic        rst;
   logic        sw_gate_en, sw_force_en, req, busy, clr;

   logic        gnt_a, clk_en_a, gnt_b, clk_en_b;
   logic [1:0]  state_a, state_b;
   logic [31:0] gated_a, gated_b;
   logic [15:0] wakes_a, wakes_b;

   int vectors = 0;
   int miscompares = 0;
   int n;
   int snap;
   bit quiet;

   always #5 clk = ~clk;

   caesar_clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE_A)) dut_a (
      .clk_i(clk), .rst_i(rst), .sw_gate_en_i(sw_gate_en), .sw_force_en_i(sw_force_en),
      .req_i(req), .busy_i(busy), .gnt_o(gnt_a), .clk_en_o(clk_en_a), .state_o(state_a),
      .clr_stats_i(clr), .gated_cycles_o(gated_a), .wake_events_o(wakes_a));

   caesar_clk_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE_B)) dut_b (
      .clk_i(clk), .rst_i(rst), .sw_gate_en_i(sw_gate_en), .sw_force_en_i(sw_force_en),
      .req_i(req), .busy_i(busy), .gnt_o(gnt_b), .clk_en_o(clk_en_b), .state_o(state_b),
      .clr_stats_i(clr), .gated_cycles_o(gated_b), .wake_events_o(wakes_b));

   // Reference model: mode 0=GATED 1=WAKE 2=ACTIVE, with the number of
   // cycles already spent waking and the length of the current idle run.
   typedef struct {
      int          mode;
      int          wake_elapsed;
      int          idle_run;
      longint      gated;
      int          wakes;
   } model_t;

   model_t ma, mb;

   function automatic model_t mreset();
      model_t r;
      r.mode = 0; r.wake_elapsed = 0; r.idle_run = 0; r.gated = 0; r.wakes = 0;
      return r;
   endfunction

   function automatic model_t mstep(model_t m, int wcyc, logic r_req, logic r_busy,
                                    logic r_force, logic r_gate_en, logic r_clr);
      model_t nx = m;
      bit     wants = r_req | r_busy | r_force | !r_gate_en;
      if (r_clr) begin
         nx.gated = 0;
         nx.wakes = 0;
      end else if (m.mode == 0 && m.gated < 64'h0000_0000_FFFF_FFFF) begin
         nx.gated = m.gated + 1;
      end
      case (m.mode)
         0: if (wants) begin
               nx.mode = (wcyc == 0) ? 2 : 1;
               nx.wake_elapsed = 0;
               nx.idle_run = 0;
               if (!r_clr && m.wakes < 65535) nx.wakes = m.wakes + 1;
            end
         1: begin
               nx.wake_elapsed = m.wake_elapsed + 1;
               if (nx.wake_elapsed >= wcyc) begin
                  nx.mode = 2;
                  nx.idle_run = 0;
               end
            end
         default: begin
               if (wants) nx.idle_run = 0;
               else begin
                  nx.idle_run = m.idle_run + 1;
                  if (nx.idle_run >= IDLE) nx.mode = 0;
               end
            end
      endcase
      return nx;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("a.state",  32'(state_a),  32'(ma.mode));
      check("a.clk_en", 32'(clk_en_a), 32'(ma.mode != 0));
      check("a.gnt",    32'(gnt_a),    32'(ma.mode == 2 && req));
      check("a.gated",  gated_a,       32'(ma.gated));
      check("a.wakes",  32'(wakes_a),  32'(ma.wakes));
      check("b.state",  32'(state_b),  32'(mb.mode));
      check("b.clk_en", 32'(clk_en_b), 32'(mb.mode != 0));
      check("b.gnt",    32'(gnt_b),    32'(mb.mode == 2 && req));
      check("b.gated",  gated_b,       32'(mb.gated));
      check("b.wakes",  32'(wakes_b),  32'(mb.wakes));
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) begin
         ma = mreset();
         mb = mreset();
      end else begin
         ma = mstep(ma, WAKE_A, req, busy, sw_force_en, sw_gate_en, clr);
         mb = mstep(mb, WAKE_B, req, busy, sw_force_en, sw_gate_en, clr);
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_gnt(output int cnt);
      cnt = 0;
      while (gnt_a !== 1'b1 && cnt < 40) begin
         cycle();
         cnt++;
      end
   endtask

   task automatic wait_active(output int cnt);
      cnt = 0;
      while (state_a !== 2'd2 && cnt < 40) begin
         cycle();
         cnt++;
      end
   endtask

   task automatic wait_gated(output int cnt);
      cnt = 0;
      while (clk_en_a !== 1'b0 && cnt < 60) begin
         cycle();
         cnt++;
      end
   endtask

   initial begin
      rst = 1'b1; sw_gate_en = 1'b1; sw_force_en = 1'b0; req = 1'b0; busy = 1'b0; clr = 1'b0;
      ma = mreset();
      mb = mreset();
      #1;
      check_all();
      cycle();
      rst = 1'b0;

      // Reset release, idle: ten gated cycles counted.
      repeat (10) cycle();
      check("idle.gated10", gated_a, 32'd10);
      check("idle.state",   32'(state_a), 32'd0);

      // Request from GATED: two WAKE cycles, grant on the third.
      req = 1'b1;
      cycle();
      check("req.a_wake",   32'(state_a), 32'd1);
      check("req.b_active", 32'(state_b), 32'd2);
      check("req.b_gnt",    32'(gnt_b),   32'd1);
      wait_gnt(n);
      check("req.latency", 32'(n + 1), 32'(WAKE_A + 1));
      check("req.wakes",   32'(wakes_a), 32'd1);
      req = 1'b0;
      wait_gated(n);
      check("idle.to_gate", 32'(n), 32'(IDLE));

      // Fifteen idle cycles, one busy cycle, then a full idle run again.
      req = 1'b1;
      wait_gnt(n);
      req = 1'b0;
      repeat (IDLE - 1) cycle();
      busy = 1'b1;
      cycle();
      busy = 1'b0;
      check("busy.active", 32'(state_a), 32'd2);
      wait_gated(n);
      check("busy.restart", 32'(n), 32'(IDLE));

      // Request arriving on what would be the terminal idle cycle.
      req = 1'b1;
      wait_gnt(n);
      req = 1'b0;
      repeat (IDLE - 1) cycle();
      req = 1'b1;
      cycle();
      check("term.state", 32'(state_a), 32'd2);
      check("term.gnt",   32'(gnt_a),   32'd1);
      req = 1'b0;
      wait_gated(n);

      // Force on for 100 cycles.
      sw_force_en = 1'b1;
      cycle();
      snap = int'(gated_a);
      repeat (100) cycle();
      check("force.state", 32'(state_a), 32'd2);
      check("force.gated", gated_a, 32'(snap));
      sw_force_en = 1'b0;
      wait_gated(n);

      // Gating disabled from GATED wakes like a request.
      sw_gate_en = 1'b0;
      wait_active(n);
      check("gate_en.latency", 32'(n), 32'(WAKE_A + 1));
      sw_gate_en = 1'b1;
      wait_gated(n);

      // Reset pulsed in the middle of WAKE.
      req = 1'b1;
      cycle();
      #2;
      rst = 1'b1;
      #1;
      ma = mreset();
      mb = mreset();
      check_all();
      check("rst.clk_en", 32'(clk_en_a), 32'd0);
      @(negedge clk);
      check_all();
      rst = 1'b0;
      wait_gnt(n);
      check("rst.relatency", 32'(n), 32'(WAKE_A + 1));
      req = 1'b0;
      wait_gated(n);

      // Saturation of the gated-cycle counter.
      force dut_a.gated_cycles_q = 32'hFFFF_FFFD;
      #1;
      release dut_a.gated_cycles_q;
      ma.gated = 64'h0000_0000_FFFF_FFFD;
      repeat (4) cycle();
      check("sat.gated", gated_a, 32'hFFFF_FFFF);

      // Clear wins over a same-cycle increment.
      clr = 1'b1;
      cycle();
      clr = 1'b0;
      check("clr.gated", gated_a, 32'd0);
      check("clr.wakes", 32'(wakes_a), 32'd0);

      // Randomised traffic with quiet stretches that allow gating.
      for (int i = 0; i < 600; i++) begin
         quiet = ((i / 40) % 2) == 1;
         req         = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
         busy        = quiet ? 1'b0 : ($urandom_range(0, 4) == 0);
         sw_force_en = quiet ? 1'b0 : ($urandom_range(0, 19) == 0);
         sw_gate_en  = quiet ? 1'b1 : ($urandom_range(0, 14) != 0);
         clr         = ($urandom_range(0, 39) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
